// File: rtl/mult_karatsuba_ctrl.sv
// mult_karatsuba_ctrl
//   Sequencer for the 8x8 Karatsuba multiplier datapath (REG1/REG2/REG3, addsub unit,
//   5x5 multiplier ROM, operand muxes). On START it walks a fixed micro-sequence and
//   pulses DONE once RES holds the product. No data passes through this block.
//
// Parameters
//   ADDSUB_LAT              addsub result latency in cycles (0..3); addsub steps last
//                           ADDSUB_LAT+1 cycles
// Ports
//   CLK                     clock, rising edge
//   RST                     synchronous reset, active high
//   START                   start request (ignored while BUSY)
//   BUSY                    high in every state except IDLE and DONE_ST
//   DONE                    one-cycle pulse, RES valid
//   LOAD_REG1/2/3, LOAD_RES register load enables
//   OP                      addsub operation, 0 = add, 1 = subtract
//   MUX_CONTROL_LOAD_REG1   REG1 input select
//   MUX_CONTROL_SUM_SUB     addsub operand-pair select
//   MUX_CONTROL_ROM         ROM factor select
module mult_karatsuba_ctrl #(
    parameter int unsigned ADDSUB_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic       LOAD_REG1,
    output logic       LOAD_REG2,
    output logic       LOAD_REG3,
    output logic       LOAD_RES,
    output logic       OP,
    output logic [2:0] MUX_CONTROL_LOAD_REG1,
    output logic [2:0] MUX_CONTROL_SUM_SUB,
    output logic [1:0] MUX_CONTROL_ROM
);

    typedef enum logic [3:0] {
        StIdle, StLdOps, StSumX, StSumYMid, StMulHi, StMulLo,
        StSubMid, StCombine, StFinal, StDoneSt
    } state_e;

    localparam logic [1:0] LastCnt = 2'(ADDSUB_LAT);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       is_addsub, step_last, load_last;

    logic       busy_d, done_d, load_reg1_d, load_reg2_d, load_reg3_d, load_res_d, op_d;
    logic [2:0] mux_reg1_d, mux_sum_sub_d;
    logic [1:0] mux_rom_d;

    // Next state and wait counter; the counter clears on every step entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_addsub = (state_q == StSumX)   || (state_q == StSumYMid) ||
                    (state_q == StSubMid) || (state_q == StCombine) ||
                    (state_q == StFinal);
        step_last = !is_addsub || (cnt_q == LastCnt);
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StLdOps;
                    cnt_d   = 2'd0;
                end
            end
            StDoneSt: begin
                state_d = START ? StLdOps : StIdle;
                cnt_d   = 2'd0;
            end
            default: begin
                if (step_last) begin
                    cnt_d = 2'd0;
                    unique case (state_q)
                        StLdOps:   state_d = StSumX;
                        StSumX:    state_d = StSumYMid;
                        StSumYMid: state_d = StMulHi;
                        StMulHi:   state_d = StMulLo;
                        StMulLo:   state_d = StSubMid;
                        StSubMid:  state_d = StCombine;
                        StCombine: state_d = StFinal;
                        StFinal:   state_d = StDoneSt;
                        default:   state_d = StIdle;
                    endcase
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered copies line up
    // exactly with the registered state (Moore behaviour, no START-to-output path).
    always_comb begin
        busy_d        = 1'b0;
        done_d        = 1'b0;
        load_reg1_d   = 1'b0;
        load_reg2_d   = 1'b0;
        load_reg3_d   = 1'b0;
        load_res_d    = 1'b0;
        op_d          = 1'b0;
        mux_reg1_d    = 3'b000;
        mux_sum_sub_d = 3'b000;
        mux_rom_d     = 2'b00;
        load_last     = (cnt_d == LastCnt);
        unique case (state_d)
            StLdOps: begin
                busy_d      = 1'b1;
                load_reg1_d = 1'b1;
            end
            StSumX: begin
                busy_d      = 1'b1;
                load_reg3_d = load_last;
            end
            StSumYMid: begin
                busy_d        = 1'b1;
                mux_sum_sub_d = 3'b001;
                load_reg2_d   = load_last;
            end
            StMulHi: begin
                busy_d      = 1'b1;
                mux_rom_d   = 2'b10;
                mux_reg1_d  = 3'b010;
                load_reg1_d = 1'b1;
            end
            StMulLo: begin
                busy_d      = 1'b1;
                mux_rom_d   = 2'b01;
                mux_reg1_d  = 3'b001;
                load_reg1_d = 1'b1;
            end
            StSubMid: begin
                busy_d        = 1'b1;
                mux_sum_sub_d = 3'b100;
                op_d          = 1'b1;
                load_reg3_d   = load_last;
            end
            StCombine: begin
                busy_d        = 1'b1;
                mux_sum_sub_d = 3'b011;
                mux_reg1_d    = 3'b011;
                load_reg1_d   = load_last;
            end
            StFinal: begin
                busy_d        = 1'b1;
                mux_sum_sub_d = 3'b101;
                mux_reg1_d    = 3'b100;
                load_reg1_d   = load_last;
                load_res_d    = load_last;
            end
            StDoneSt: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q               <= StIdle;
            cnt_q                 <= 2'd0;
            BUSY                  <= 1'b0;
            DONE                  <= 1'b0;
            LOAD_REG1             <= 1'b0;
            LOAD_REG2             <= 1'b0;
            LOAD_REG3             <= 1'b0;
            LOAD_RES              <= 1'b0;
            OP                    <= 1'b0;
            MUX_CONTROL_LOAD_REG1 <= 3'b000;
            MUX_CONTROL_SUM_SUB   <= 3'b000;
            MUX_CONTROL_ROM       <= 2'b00;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            BUSY                  <= busy_d;
            DONE                  <= done_d;
            LOAD_REG1             <= load_reg1_d;
            LOAD_REG2             <= load_reg2_d;
            LOAD_REG3             <= load_reg3_d;
            LOAD_RES              <= load_res_d;
            OP                    <= op_d;
            MUX_CONTROL_LOAD_REG1 <= mux_reg1_d;
            MUX_CONTROL_SUM_SUB   <= mux_sum_sub_d;
            MUX_CONTROL_ROM       <= mux_rom_d;
        end
    end

endmodule

// File: tb/tb_mult_karatsuba_ctrl.sv
// Bench for mult_karatsuba_ctrl: three instances (ADDSUB_LAT = 0, 1, 3) share stimulus.
// Output vector layout: [14] BUSY [13] DONE [12] LOAD_REG1 [11] LOAD_REG2 [10] LOAD_REG3
//                       [9] LOAD_RES [8] OP [7:5] MUX REG1 [4:2] MUX SUM_SUB [1:0] MUX ROM
module tb_mult_karatsuba_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic START;
    always #5 CLK = ~CLK;

    wire [14:0] v0, v1, v3;

    mult_karatsuba_ctrl #(.ADDSUB_LAT(0)) dut0 (
        .CLK(CLK), .RST(RST), .START(START),
        .BUSY(v0[14]), .DONE(v0[13]), .LOAD_REG1(v0[12]), .LOAD_REG2(v0[11]),
        .LOAD_REG3(v0[10]), .LOAD_RES(v0[9]), .OP(v0[8]),
        .MUX_CONTROL_LOAD_REG1(v0[7:5]), .MUX_CONTROL_SUM_SUB(v0[4:2]),
        .MUX_CONTROL_ROM(v0[1:0])
    );
    mult_karatsuba_ctrl #(.ADDSUB_LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(START),
        .BUSY(v1[14]), .DONE(v1[13]), .LOAD_REG1(v1[12]), .LOAD_REG2(v1[11]),
        .LOAD_REG3(v1[10]), .LOAD_RES(v1[9]), .OP(v1[8]),
        .MUX_CONTROL_LOAD_REG1(v1[7:5]), .MUX_CONTROL_SUM_SUB(v1[4:2]),
        .MUX_CONTROL_ROM(v1[1:0])
    );
    mult_karatsuba_ctrl #(.ADDSUB_LAT(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(START),
        .BUSY(v3[14]), .DONE(v3[13]), .LOAD_REG1(v3[12]), .LOAD_REG2(v3[11]),
        .LOAD_REG3(v3[10]), .LOAD_RES(v3[9]), .OP(v3[8]),
        .MUX_CONTROL_LOAD_REG1(v3[7:5]), .MUX_CONTROL_SUM_SUB(v3[4:2]),
        .MUX_CONTROL_ROM(v3[1:0])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Step table: addsub flag, loads {REG1,REG2,REG3,RES}, op, reg1 sel, sum_sub sel, rom sel.
    bit         st_add [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] st_ld  [8] = '{4'b1000, 4'b0010, 4'b0100, 4'b1000,
                               4'b1000, 4'b0010, 4'b1000, 4'b1001};
    logic       st_op  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] st_r1  [8] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd3, 3'd4};
    logic [2:0] st_ss  [8] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd4, 3'd3, 3'd5};
    logic [1:0] st_rom [8] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

    // Model: position within a run (0 = idle, 1.. = cycle since the START edge).
    int pos0 = 0, pos1 = 0, pos3 = 0;

    function automatic int next_pos(int p, int lat, logic r, logic s);
        if (r) return 0;
        if (p == 0 || p == 9 + 5 * lat) return s ? 1 : 0;
        return p + 1;
    endfunction

    function automatic logic [14:0] exp_vec(int lat, int pos);
        logic [14:0] v;
        int p;
        int d;
        logic last;
        v = '0;
        if (pos == 0) return v;
        if (pos == 9 + 5 * lat) begin
            v[13] = 1'b1;
            return v;
        end
        v[14] = 1'b1;
        p = pos - 1;
        for (int i = 0; i < 8; i++) begin
            d = st_add[i] ? lat + 1 : 1;
            if (p < d) begin
                last    = (p == d - 1);
                v[12]   = st_ld[i][3] & last;
                v[11]   = st_ld[i][2] & last;
                v[10]   = st_ld[i][1] & last;
                v[9]    = st_ld[i][0] & last;
                v[8]    = st_op[i];
                v[7:5]  = st_r1[i];
                v[4:2]  = st_ss[i];
                v[1:0]  = st_rom[i];
                return v;
            end
            p = p - d;
        end
        return v;
    endfunction

    always @(posedge CLK) begin
        pos0 <= next_pos(pos0, 0, RST, START);
        pos1 <= next_pos(pos1, 1, RST, START);
        pos3 <= next_pos(pos3, 3, RST, START);
    end

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_lat0", v0, exp_vec(0, pos0));
            check("model_lat1", v1, exp_vec(1, pos1));
            check("model_lat3", v3, exp_vec(3, pos3));
        end
    end

    task automatic idle(input int n);
        START = 1'b0;
        RST   = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    // Pulse START, then watch n_cycles cycles; returns first DONE cycle and DONE count.
    task automatic run(input bit repulse, input bit hold, input int rst_at, input int n_cycles,
                       output int f0, output int f1, output int f3,
                       output int c0, output int c1, output int c3);
        f0 = -1; f1 = -1; f3 = -1;
        c0 = 0;  c1 = 0;  c3 = 0;
        START = 1'b1;
        RST   = 1'b0;
        for (int n = 1; n <= n_cycles; n++) begin
            @(negedge CLK);
            START = hold || (repulse && (n == 2 || n == 9));
            RST   = (n == rst_at);
            if (v0[13]) begin c0++; if (f0 < 0) f0 = n; end
            if (v1[13]) begin c1++; if (f1 < 0) f1 = n; end
            if (v3[13]) begin c3++; if (f3 < 0) f3 = n; end
            if (n == 13 && rst_at < 0) check("load_res_last_final", 15'(v1[9]), 15'd1);
            if (hold && n == 15) check("ldops_after_done", v1, 15'h5000);
            if (rst_at > 0 && n == rst_at) check("in_sub_mid", v1, 15'h4110);
            if (rst_at > 0 && n == rst_at + 1) check("rst_abort_idle", v1, 15'h0000);
        end
        START = 1'b0;
        RST   = 1'b0;
    endtask

    int f0, f1, f3, c0, c1, c3;

    initial begin
        RST   = 1'b1;
        START = 1'b1;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_lat0", v0, 15'h0000);
        check("reset_lat1", v1, 15'h0000);
        check("reset_lat3", v3, 15'h0000);
        idle(2);

        // Single operation.
        run(1'b0, 1'b0, -1, 30, f0, f1, f3, c0, c1, c3);
        check("latency_lat0", 15'(f0), 15'd9);
        check("latency_lat1", 15'(f1), 15'd14);
        check("latency_lat3", 15'(f3), 15'd24);
        check("done_once_lat1", 15'(c1), 15'd1);
        check("done_once_lat3", 15'(c3), 15'd1);
        idle(30);

        // START re-pulsed mid-run is ignored.
        run(1'b1, 1'b0, -1, 40, f0, f1, f3, c0, c1, c3);
        check("repulse_latency", 15'(f1), 15'd14);
        check("repulse_done_cnt", 15'(c1), 15'd1);
        idle(30);

        // START held: back-to-back runs.
        run(1'b0, 1'b1, -1, 56, f0, f1, f3, c0, c1, c3);
        check("held_first_done", 15'(f1), 15'd14);
        check("held_done_cnt_lat1", 15'(c1), 15'd4);
        check("held_done_cnt_lat0", 15'(c0), 15'd6);
        check("held_done_cnt_lat3", 15'(c3), 15'd2);
        idle(30);

        // Reset in SUB_MID aborts, then a fresh run completes.
        run(1'b0, 1'b0, 8, 12, f0, f1, f3, c0, c1, c3);
        check("abort_no_done", 15'(c1), 15'd0);
        idle(3);
        run(1'b0, 1'b0, -1, 30, f0, f1, f3, c0, c1, c3);
        check("after_abort_latency", 15'(f1), 15'd14);
        idle(30);

        // Randomised START / RST traffic.
        for (int i = 0; i < 800; i++) begin
            START = ($urandom_range(3) == 0);
            RST   = ($urandom_range(59) == 0);
            @(negedge CLK);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
